sync_fifo_flags: RTL and testbench

//  Parametrised single-clock FIFO, successor to the basic fifo block.

---
 rtl/sync_fifo_flags.sv | 124 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN to select first-word-fall-through reads; the default is registered reads.
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              re,
  output logic [WIDTH-1:0]  data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_ok, rd_ok;

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  always_comb begin
    wr_ok    = we & (~full_q | re);
    rd_ok    = re & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    count_d  = count_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    // A new error in the same cycle as the clear keeps the flag set.
    if (we & full_q & ~re) ovf_d = 1'b1;
    if (re & empty_q)      unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = empty_q ? '0 : mem_q[rd_ptr_q];
  assign rd_valid = ~empty_q;
`else
  logic [WIDTH-1:0] dout_q;
  logic             rdv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      rdv_q  <= 1'b0;
    end else begin
      rdv_q <= rd_ok;
      if (rd_ok) dout_q <= mem_q[rd_ptr_q];
    end
  end

  assign data_out = dout_q;
  assign rd_valid = rdv_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomized and directed bench for sync_fifo_flags against a queue-based reference model.
module tb_sync_fifo_flags;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int AF_THRESH = 12;
  localparam int AE_THRESH = 4;

  logic             clk, rst_n, we, re, clr_err;
  logic [WIDTH-1:0] data_in, data_out;
  logic             rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [ADDR_W:0]  count;

  int tests = 0;
  int fails = 0;
  bit check_en = 0;

  sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                    .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .data_in(data_in), .re(re),
    .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference model: contents as a queue, errors and last popped word as plain variables.
  logic [WIDTH-1:0] mq[$];
  logic             m_ovf, m_unf, m_rdv;
  logic [WIDTH-1:0] m_dout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_rdv = 0; m_dout = 0;
    end else begin
      bit was_full, was_empty, pop, push;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      pop  = re && !was_empty;
      push = we && (!was_full || re);
      m_rdv = pop;
      if (pop) m_dout = mq.pop_front();
      if (push) mq.push_back(data_in);
      if (clr_err) begin m_ovf = 0; m_unf = 0; end
      if (we && was_full && !re) m_ovf = 1;
      if (re && was_empty) m_unf = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      int n;
      n = mq.size();
      chk("cmp_count", 32'(count), 32'(n));
      chk("cmp_full", 32'(full), 32'(n == DEPTH));
      chk("cmp_empty", 32'(empty), 32'(n == 0));
      chk("cmp_afull", 32'(almost_full), 32'(n >= AF_THRESH));
      chk("cmp_aempty", 32'(almost_empty), 32'(n <= AE_THRESH));
      chk("cmp_ovf", 32'(overflow), 32'(m_ovf));
      chk("cmp_unf", 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
      chk("cmp_dout", 32'(data_out), (n == 0) ? 32'd0 : 32'(mq[0]));
      chk("cmp_rdv", 32'(rd_valid), 32'(n != 0));
`else
      chk("cmp_dout", 32'(data_out), 32'(m_dout));
      chk("cmp_rdv", 32'(rd_valid), 32'(m_rdv));
`endif
    end
  end

  task automatic drive(input logic w, input logic r, input logic [WIDTH-1:0] d, input logic c);
    we = w; re = r; data_in = d; clr_err = c;
    @(posedge clk);
    #1;
    we = 0; re = 0; clr_err = 0;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_word;
    rst_n = 0; we = 0; re = 0; clr_err = 0; data_in = 0;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_dout", 32'(data_out), 0);
    @(posedge clk); #1;
    rst_n = 1;
    check_en = 1;

    // Fill with 1..16
    for (int i = 1; i <= 16; i++) begin
      drive(1, 0, WIDTH'(i), 0);
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_aempty", 32'(almost_empty), 32'(i <= 4));
      chk("fill_afull", 32'(almost_full), 32'(i >= 12));
      chk("fill_full", 32'(full), 32'(i == 16));
      chk("fill_ovf", 32'(overflow), 0);
    end

    // Overflow while full
    drive(1, 0, 8'd17, 0);
    drive(1, 0, 8'd18, 0);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_set", 32'(overflow), 1);
    drive(0, 0, 8'd0, 1);
    chk("ovf_clr", 32'(overflow), 0);

    // Drain 1..16 then underflow
    for (int i = 1; i <= 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("drain_head", 32'(data_out), 32'(i));
`endif
      drive(0, 1, 8'd0, 0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("drain_dout", 32'(data_out), 32'(i));
      chk("drain_rdv", 32'(rd_valid), 1);
`endif
    end
    drive(0, 1, 8'd0, 0);
    drive(0, 1, 8'd0, 0);
    chk("unf_set", 32'(underflow), 1);
    chk("unf_count", 32'(count), 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("unf_dout", 32'(data_out), 0);
`else
    chk("unf_dout_hold", 32'(data_out), 16);
    chk("unf_rdv", 32'(rd_valid), 0);
`endif
    drive(0, 0, 8'd0, 1);
    chk("unf_clr", 32'(underflow), 0);

    // Asynchronous reset mid-stream with count=5
    for (int i = 0; i < 6; i++) drive(1, 0, WIDTH'(8'h30 + i), 0);
    drive(0, 1, 8'd0, 0);
    chk("pre_rst_count", 32'(count), 5);
    #2 rst_n = 0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_aempty", 32'(almost_empty), 1);
    chk("arst_dout", 32'(data_out), 0);
    chk("arst_rdv", 32'(rd_valid), 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Simultaneous read/write across pointer wrap
    for (int i = 0; i < 8; i++) drive(1, 0, WIDTH'(100 + i), 0);
    for (int j = 0; j < 20; j++) begin
      exp_word = (j < 8) ? WIDTH'(100 + j) : WIDTH'(200 + j - 8);
`ifdef SYNC_FIFO_FWFT_EN
      chk("wrap_head", 32'(data_out), 32'(exp_word));
`endif
      drive(1, 1, WIDTH'(200 + j), 0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("wrap_dout", 32'(data_out), 32'(exp_word));
`endif
      chk("wrap_count", 32'(count), 8);
    end
    for (int i = 0; i < 8; i++) drive(1, 0, WIDTH'(i), 0);
    chk("wrap_full", 32'(full), 1);
    drive(1, 1, 8'd50, 0);
    chk("fullrw_count", 32'(count), 16);
    chk("fullrw_ovf", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) drive(0, 1, 8'd0, 0);
    chk("drain2_empty", 32'(empty), 1);

    // Single word into empty FIFO
    drive(1, 0, 8'hA5, 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_show", 32'(data_out), 32'h A5);
    chk("fwft_rdv", 32'(rd_valid), 1);
    drive(0, 1, 8'd0, 0);
    chk("fwft_empty", 32'(empty), 1);
    chk("fwft_zero", 32'(data_out), 0);
`else
    drive(0, 1, 8'd0, 0);
    chk("std_pop", 32'(data_out), 32'h A5);
    chk("std_empty", 32'(empty), 1);
`endif

    // Randomized traffic, alternating write-heavy and read-heavy phases
    for (int n = 0; n < 600; n++) begin
      int wp;
      wp = ((n / 100) % 2 == 0) ? 75 : 25;
      drive($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
            WIDTH'($urandom), $urandom_range(0, 19) == 0);
    end

    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
